// File: rtl/com_uart.sv
// com_uart: 8-bit UART peripheral on the CPU COM bus.
//
// Register map (relative to BASE):
//   +0 DATA   read: RX holding byte        write: push TX FIFO (dropped when full)
//   +1 STATUS read: {3'b0, rx_ovr, rx_valid, tx_busy, tx_full, tx_empty}
//             write: bit0 pops rx_valid, bit1 clears rx_ovr
//   +2 DIVL / +3 DIVH : 16-bit baud divider, bit period = DIV+1 clocks
//   +4 IEN    bit0 RX interrupt enable, bit1 TX-empty interrupt enable
//
// Ports:
//   clk        system clock
//   rst        synchronous reset, active low
//   com_addr   COM address from core (0 = bus idle); any mapped address is a write
//   com_wr     COM write data
//   com_rd     COM read data (combinational, 0 when unmapped, cause code on interrupt)
//   interrupt  one-cycle interrupt request
//   uart_tx    serial output, idle high
//   uart_rx    serial input, asynchronous
module com_uart #(
    parameter logic [7:0]  BASE      = 8'h10,
    parameter int          TX_DEPTH  = 4,
    parameter logic [15:0] DIV_RESET = 16'd433,
    parameter logic [7:0]  INTR_RX   = 8'h01,
    parameter logic [7:0]  INTR_TX   = 8'h02
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] com_addr,
    input  logic [7:0] com_wr,
    output logic [7:0] com_rd,
    output logic       interrupt,
    output logic       uart_tx,
    input  logic       uart_rx
);
    localparam int PW = $clog2(TX_DEPTH);
    localparam logic [PW:0] FULL_COUNT = (PW+1)'(TX_DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

    // Bus decode
    logic sel_data, sel_stat, sel_divl, sel_divh, sel_ien;
    assign sel_data = (com_addr == BASE);
    assign sel_stat = (com_addr == BASE + 8'd1);
    assign sel_divl = (com_addr == BASE + 8'd2);
    assign sel_divh = (com_addr == BASE + 8'd3);
    assign sel_ien  = (com_addr == BASE + 8'd4);

    // Control registers
    logic [15:0] div_reg;
    logic [1:0]  ien_reg;

    always_ff @(posedge clk) begin
        if (!rst) begin
            div_reg <= DIV_RESET;
            ien_reg <= 2'b00;
        end else begin
            if (sel_divl) div_reg[7:0]  <= com_wr;
            if (sel_divh) div_reg[15:8] <= com_wr;
            if (sel_ien)  ien_reg       <= com_wr[1:0];
        end
    end

    // TX FIFO
    logic [7:0]  tx_mem [TX_DEPTH];
    logic [PW-1:0] wr_ptr_reg, rd_ptr_reg;
    logic [PW:0] count_reg;
    logic tx_empty, tx_full, tx_push, tx_pop;
    logic [7:0] tx_head;

    state_t      tx_state_reg;
    logic [15:0] tx_cnt_reg;
    logic [2:0]  tx_bit_reg;
    logic [7:0]  tx_shift_reg;
    logic        tx_busy, tx_done;

    assign tx_empty = (count_reg == '0);
    assign tx_full  = (count_reg == FULL_COUNT);
    // Full is judged on the pre-cycle count, so a push while full is lost even if a pop frees a slot.
    assign tx_push  = sel_data && !tx_full;
    assign tx_pop   = !tx_empty && ((tx_state_reg == S_IDLE) ||
                                    (tx_state_reg == S_STOP && tx_cnt_reg == 16'd0));
    assign tx_head  = tx_mem[rd_ptr_reg];
    assign tx_busy  = (tx_state_reg != S_IDLE);
    // Last STOP clock with nothing left to send: busy falls at this edge.
    assign tx_done  = (tx_state_reg == S_STOP) && (tx_cnt_reg == 16'd0) && tx_empty;

    always_ff @(posedge clk) begin
        if (tx_push) tx_mem[wr_ptr_reg] <= com_wr;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (tx_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (tx_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
            if (tx_push && !tx_pop)      count_reg <= count_reg + 1'b1;
            else if (!tx_push && tx_pop) count_reg <= count_reg - 1'b1;
        end
    end

    // TX serialiser
    always_ff @(posedge clk) begin
        if (!rst) begin
            tx_state_reg <= S_IDLE;
            tx_cnt_reg   <= 16'd0;
            tx_bit_reg   <= 3'd0;
            tx_shift_reg <= 8'd0;
            uart_tx      <= 1'b1;
        end else begin
            case (tx_state_reg)
                S_IDLE: begin
                    if (!tx_empty) begin
                        tx_state_reg <= S_START;
                        tx_shift_reg <= tx_head;
                        tx_cnt_reg   <= div_reg;
                        uart_tx      <= 1'b0;
                    end
                end
                S_START: begin
                    if (tx_cnt_reg == 16'd0) begin
                        tx_state_reg <= S_DATA;
                        uart_tx      <= tx_shift_reg[0];
                        tx_shift_reg <= {1'b0, tx_shift_reg[7:1]};
                        tx_bit_reg   <= 3'd0;
                        tx_cnt_reg   <= div_reg;
                    end else begin
                        tx_cnt_reg <= tx_cnt_reg - 16'd1;
                    end
                end
                S_DATA: begin
                    if (tx_cnt_reg == 16'd0) begin
                        tx_cnt_reg <= div_reg;
                        if (tx_bit_reg == 3'd7) begin
                            tx_state_reg <= S_STOP;
                            uart_tx      <= 1'b1;
                        end else begin
                            uart_tx      <= tx_shift_reg[0];
                            tx_shift_reg <= {1'b0, tx_shift_reg[7:1]};
                            tx_bit_reg   <= tx_bit_reg + 3'd1;
                        end
                    end else begin
                        tx_cnt_reg <= tx_cnt_reg - 16'd1;
                    end
                end
                S_STOP: begin
                    if (tx_cnt_reg == 16'd0) begin
                        if (!tx_empty) begin
                            // Back-to-back: straight into the next start bit.
                            tx_state_reg <= S_START;
                            tx_shift_reg <= tx_head;
                            tx_cnt_reg   <= div_reg;
                            uart_tx      <= 1'b0;
                        end else begin
                            tx_state_reg <= S_IDLE;
                        end
                    end else begin
                        tx_cnt_reg <= tx_cnt_reg - 16'd1;
                    end
                end
                default: tx_state_reg <= S_IDLE;
            endcase
        end
    end

    // RX synchroniser and edge history
    logic rx_s1_reg, rx_s2_reg, rx_prev_reg;

    always_ff @(posedge clk) begin
        if (!rst) begin
            rx_s1_reg   <= 1'b1;
            rx_s2_reg   <= 1'b1;
            rx_prev_reg <= 1'b1;
        end else begin
            rx_s1_reg   <= uart_rx;
            rx_s2_reg   <= rx_s1_reg;
            rx_prev_reg <= rx_s2_reg;
        end
    end

    // RX deserialiser
    state_t      rx_state_reg;
    logic [15:0] rx_cnt_reg;
    logic [2:0]  rx_bit_reg;
    logic [7:0]  rx_shift_reg;
    logic [15:0] half_bit, start_load;
    logic        rx_load;

    // (DIV+1)>>1 without a 17-bit intermediate; the START wait is half_bit clocks.
    assign half_bit   = {1'b0, div_reg[15:1]} + {15'd0, div_reg[0]};
    assign start_load = (half_bit == 16'd0) ? 16'd0 : half_bit - 16'd1;
    assign rx_load    = (rx_state_reg == S_STOP) && (rx_cnt_reg == 16'd0) && rx_s2_reg;

    always_ff @(posedge clk) begin
        if (!rst) begin
            rx_state_reg <= S_IDLE;
            rx_cnt_reg   <= 16'd0;
            rx_bit_reg   <= 3'd0;
            rx_shift_reg <= 8'd0;
        end else begin
            case (rx_state_reg)
                S_IDLE: begin
                    if (rx_prev_reg && !rx_s2_reg) begin
                        rx_state_reg <= S_START;
                        rx_cnt_reg   <= start_load;
                    end
                end
                S_START: begin
                    if (rx_cnt_reg == 16'd0) begin
                        if (rx_s2_reg) begin
                            rx_state_reg <= S_IDLE;   // glitch, not a start bit
                        end else begin
                            rx_state_reg <= S_DATA;
                            rx_cnt_reg   <= div_reg;
                            rx_bit_reg   <= 3'd0;
                        end
                    end else begin
                        rx_cnt_reg <= rx_cnt_reg - 16'd1;
                    end
                end
                S_DATA: begin
                    if (rx_cnt_reg == 16'd0) begin
                        rx_shift_reg <= {rx_s2_reg, rx_shift_reg[7:1]};
                        rx_cnt_reg   <= div_reg;
                        if (rx_bit_reg == 3'd7) rx_state_reg <= S_STOP;
                        else                    rx_bit_reg   <= rx_bit_reg + 3'd1;
                    end else begin
                        rx_cnt_reg <= rx_cnt_reg - 16'd1;
                    end
                end
                S_STOP: begin
                    if (rx_cnt_reg == 16'd0) rx_state_reg <= S_IDLE;
                    else                     rx_cnt_reg   <= rx_cnt_reg - 16'd1;
                end
                default: rx_state_reg <= S_IDLE;
            endcase
        end
    end

    // RX holding register and status flags
    logic [7:0] rx_data_reg;
    logic       rx_valid_reg, rx_ovr_reg;
    logic       rx_pop, ovr_clr, rx_set;

    assign rx_pop  = sel_stat && com_wr[0];
    assign ovr_clr = sel_stat && com_wr[1];
    assign rx_set  = rx_load && !rx_valid_reg;

    always_ff @(posedge clk) begin
        if (!rst) begin
            rx_data_reg  <= 8'd0;
            rx_valid_reg <= 1'b0;
            rx_ovr_reg   <= 1'b0;
        end else begin
            // A pop in the same cycle as a load makes room for the new byte.
            if (rx_load && (!rx_valid_reg || rx_pop)) begin
                rx_data_reg  <= rx_shift_reg;
                rx_valid_reg <= 1'b1;
            end else if (rx_pop) begin
                rx_valid_reg <= 1'b0;
            end
            if (rx_load && rx_valid_reg && !rx_pop) rx_ovr_reg <= 1'b1;
            else if (ovr_clr)                       rx_ovr_reg <= 1'b0;
        end
    end

    // Interrupt sequencing: RX wins a tie, TX is held one cycle.
    logic [7:0] cause_reg;
    logic       tx_pend_reg, rx_evt, tx_evt;

    assign rx_evt = rx_set && ien_reg[0];
    assign tx_evt = tx_done && ien_reg[1];

    always_ff @(posedge clk) begin
        if (!rst) begin
            interrupt   <= 1'b0;
            cause_reg   <= 8'd0;
            tx_pend_reg <= 1'b0;
        end else if (rx_evt) begin
            interrupt   <= 1'b1;
            cause_reg   <= INTR_RX;
            tx_pend_reg <= tx_pend_reg || tx_evt;
        end else if (tx_evt || tx_pend_reg) begin
            interrupt   <= 1'b1;
            cause_reg   <= INTR_TX;
            tx_pend_reg <= 1'b0;
        end else begin
            interrupt   <= 1'b0;
        end
    end

    // Read mux
    always_comb begin
        com_rd = 8'd0;
        if (interrupt)     com_rd = cause_reg;
        else if (sel_data) com_rd = rx_data_reg;
        else if (sel_stat) com_rd = {3'b000, rx_ovr_reg, rx_valid_reg, tx_busy, tx_full, tx_empty};
        else if (sel_divl) com_rd = div_reg[7:0];
        else if (sel_divh) com_rd = div_reg[15:8];
        else if (sel_ien)  com_rd = {6'd0, ien_reg};
    end

endmodule
